product_rx: RTL
===============

# product_rx

Serial receiver that sits directly downstream of the Booth multiplier's one-bit-per-clock `tx` output. It reframes the 10-bit serial frame back into the signed 8-bit product. The frame is a start bit of 0, then 8 data bits LSB first, then a stop bit of 1. Recovered words are buffered in a small FIFO and handed to the consumer over a valid/ready handshake. The block also flags framing errors and overflow.

## Interface
- `DATA_W`, default 8: product width; equals the number of data bits per frame.
- `DEPTH`, default 2: output FIFO depth; must be a power of 2, ≥ 2.
- `CLK` (input, 1): global clock; same clock as the transmitter, all logic on posedge.
- `RST_N` (input, 1): asynchronous, active-low reset.
- `rx` (input, 1): serial line, driven by the multiplier's `tx`; one bit per `CLK`.
- `product` (output, `DATA_W`, signed): FIFO head word.
- `out_valid` (output, 1): `product` holds a valid word.
- `out_ready` (input, 1): consumer accepts the head word on an edge where `out_valid && out_ready`.
- `frame_err` (output, 1): one-cycle pulse when a stop bit is sampled as 0.
- `err_cnt` (output, 8): count of framing errors, saturating at 255.
- `overflow` (output, 1): sticky; set when a good frame is dropped because the FIFO is full.

## Operation
- Outputs at reset: `product`=0, `out_valid`=0, `frame_err`=0, `err_cnt`=0, `overflow`=0. Reset also sets FSM=IDLE, bit index=0, and empties the FIFO.
- FSM states: IDLE, DATA, STOP, RESYNC. `rx` is sampled once per posedge.
- IDLE:
  - `rx`=0 → DATA, bit index=0.
  - Otherwise stay in IDLE.
- DATA:
  - Each edge, shift reg[index] ← `rx`, then index+1.
  - After the sample at index `DATA_W`-1 → STOP.
- STOP, `rx`=1 (good frame):
  - Push the shift register into the FIFO; next state IDLE.
  - If the FIFO is full and no pop happens on the same edge: drop the word and set `overflow`.
- STOP, `rx`=0 (framing error):
  - Pulse `frame_err`; `err_cnt`+1, saturating at 255; nothing is pushed.
  - Next state RESYNC.
- RESYNC: wait for `rx`=1, then → IDLE. This prevents a 0 stop bit from being taken as a start bit.
- Frames may arrive back to back (start bit immediately after stop bit). IDLE must accept a start bit on the edge right after STOP, with no gap cycle.
- Bits are reassembled with no arithmetic. `product` is the raw two's-complement word; the upper bits form the accumulator half and the lower 4 bits the Q half.
- Starting reception mid-stream may mis-frame, because a 0 data bit seen in IDLE is taken as a start bit. Recovery happens through RESYNC after a framing error; no further detection is required.

## Timing
- Frame length: 10 cycles. Maximum throughput: one word per 10 cycles.
- Latency: when the stop bit is sampled at edge N into an empty FIFO, `out_valid`=1 and `product` are valid after edge N. The word can be popped at edge N+1.
- `frame_err` is high for exactly the one cycle after the edge that samples the bad stop bit.
- FIFO boundary cases:
  - Push and pop on the same edge while full: both happen, no overflow.
  - Push and pop on the same edge while empty-pending (the push lands in an empty FIFO): the word becomes visible after that edge; it is not popped.
  - Pop while empty: ignored.
- FIFO pointers wrap modulo `DEPTH`. The count ranges from 0 to `DEPTH`.
- `product` holds its value while `out_valid`=1 and `out_ready`=0.
- Asserting `RST_N` low mid-frame clears everything immediately, without waiting for a clock edge. The partial frame is discarded.

## Structure
- Package `product_rx_pkg` holds:
  - The state enum (IDLE, DATA, STOP, RESYNC).
  - Constants `START_BIT`=0, `STOP_BIT`=1, `FRAME_BITS`=`DATA_W`+2.
  - `ERR_CNT_MAX`=255.
- One sub-module, `rx_fifo`: a parameterised synchronous FIFO with push/pop, full/empty and a registered head output, reset by `RST_N`.
- The FSM, shift register and error counter live in `product_rx`.

## Test plan
- Single good frame for 3×−2 = 8'hFA: `rx` sequence 0,0,1,0,1,1,1,1,1,1 with `out_ready`=1 → `out_valid` is high for one cycle after the stop edge with `product`=8'hFA; `frame_err` stays 0.
- Back-to-back frames of 8'h0C (3×4) then 8'hF1 (−5×3), with `out_ready`=0 → both are buffered in order; the FIFO is full. A third frame of 8'h01 is dropped and sets `overflow`=1. Raising `out_ready` then yields 8'h0C, then 8'hF1.
- Bad stop bit: frame 0, then 8 ones, then stop=0, then `rx` held 0 for 3 cycles, then 1 → one `frame_err` pulse and `err_cnt`=1. Nothing is pushed. The next good frame of 8'h55 is received correctly.
- 256 consecutive bad frames → `err_cnt` saturates at 255 and does not wrap.
- Full FIFO, then a push and pop on the same edge → occupancy stays at `DEPTH`, `overflow` stays 0, and output order is preserved.
- `RST_N` low for 1 cycle at data bit 4 → all outputs read 0 and the FIFO is empty. The following complete frame of 8'h80 is received correctly.

Source files
------------

// File: rtl/product_rx_pkg.sv
// Shared types and framing constants for the serial product receiver.
package product_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    STOP   = 2'd2,
    RESYNC = 2'd3
  } rx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int DATA_W_DEF = 8;
  localparam int FRAME_BITS = DATA_W_DEF + 2;

  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == ERR_CNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/product_rx_if.sv
// Serial line in, buffered product handshake and error status out.
interface product_rx_if #(
  parameter int DATA_W = 8
);

  logic                     rx;
  logic signed [DATA_W-1:0] product;
  logic                     out_valid;
  logic                     out_ready;
  logic                     frame_err;
  logic [7:0]               err_cnt;
  logic                     overflow;

  modport master (
    output rx,
    output out_ready,
    input  product,
    input  out_valid,
    input  frame_err,
    input  err_cnt,
    input  overflow
  );

  modport slave (
    input  rx,
    input  out_ready,
    output product,
    output out_valid,
    output frame_err,
    output err_cnt,
    output overflow
  );

endinterface

// File: rtl/rx_fifo.sv
// Small synchronous FIFO whose head word is held in its own register,
// so the consumer sees a flop output rather than a memory read mux.
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q,  head_d;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = head_q;

  // A push into a full FIFO is only accepted when a pop frees a slot on the same edge.
  always_comb begin
    doPop   = pop_i && !empty_o;
    doPush  = push_i && (!full_o || doPop);
    rdPtr_d = rdPtr_q + AW'(doPop);
    wrPtr_d = wrPtr_q + AW'(doPush);
    count_d = count_q + (AW + 1)'(doPush) - (AW + 1)'(doPop);
    head_d  = head_q;
    if (count_d != '0) begin
      if (doPush && (wrPtr_q == rdPtr_d)) begin
        head_d = data_i;
      end else begin
        head_d = mem_q[rdPtr_d];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= data_i;
      end
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

endmodule

// File: rtl/product_rx.sv
// Reframes the multiplier's start/8-data/stop serial stream into signed
// products, buffers them, and reports framing errors and FIFO overflow.
module product_rx
  import product_rx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input logic       CLK,
  input logic       RST_N,
  product_rx_if.slave bus
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  rx_state_e         state_q;
  logic [IW-1:0]     idx_q;
  logic [DATA_W-1:0] shift_q;
  logic              frameErr_q;
  logic [7:0]        errCnt_q;
  logic              overflow_q;

  logic              goodStop;
  logic              popWord;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [DATA_W-1:0] fifoHead;

  assign goodStop = (state_q == STOP) && (bus.rx == STOP_BIT);
  assign popWord  = bus.out_ready && !fifoEmpty;

  rx_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .push_i  (goodStop),
    .data_i  (shift_q),
    .pop_i   (bus.out_ready),
    .head_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // RESYNC holds off until the line returns high so a zero stop bit is never taken as a start bit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      shift_q    <= '0;
      frameErr_q <= 1'b0;
      errCnt_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      frameErr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.rx == START_BIT) begin
            state_q <= DATA;
            idx_q   <= '0;
          end
        end
        DATA: begin
          shift_q[idx_q] <= bus.rx;
          if (idx_q == LAST_IDX) begin
            state_q <= STOP;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        STOP: begin
          if (bus.rx == STOP_BIT) begin
            state_q <= IDLE;
            if (fifoFull && !popWord) begin
              overflow_q <= 1'b1;
            end
          end else begin
            state_q    <= RESYNC;
            frameErr_q <= 1'b1;
            errCnt_q   <= sat_inc(errCnt_q);
          end
        end
        RESYNC: begin
          if (bus.rx == STOP_BIT) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.product   = fifoHead;
  assign bus.out_valid = !fifoEmpty;
  assign bus.frame_err = frameErr_q;
  assign bus.err_cnt   = errCnt_q;
  assign bus.overflow  = overflow_q;

  // A bad stop bit always leads through RESYNC, so the error pulse can never stretch.
  property pFrameErrPulse;
    @(posedge CLK) disable iff (!RST_N) frameErr_q |=> !frameErr_q;
  endproperty
  assert property (pFrameErrPulse);

endmodule
